// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - shared constants and FSM state type for the AXI write responder
package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import axi_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] span_mask;
  logic [ADDR_WIDTH-1:0] sum;

  // WRAP keeps the span-aligned base bits and lets only the in-span offset roll over
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    span_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    sum       = addr + incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~span_mask) | (sum & span_mask);
      default:     next_addr = sum;
    endcase
  end

endmodule

// File: rtl/axi_wr_responder.sv
// rtl/axi_wr_responder.sv - pops AW commands, writes W beats to local memory, returns B
module axi_wr_responder
  import axi_wr_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    aw_empty,
  output logic                    aw_pop,
  input  logic [ID_WIDTH-1:0]     front_AWID,
  input  logic [ADDR_WIDTH-1:0]   front_AWADDR,
  input  logic [LEN_WIDTH-1:0]    front_AWLEN,
  input  logic [SIZE_WIDTH-1:0]   front_AWSIZE,
  input  logic [1:0]              front_AWBURST,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  wr_state_t             state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [1:0]            burst_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  err_q;

  logic                  beat;
  logic                  last_beat;
  logic                  cmd_bad;
  logic                  wrap_len_ok;
  logic [ADDR_WIDTH-1:0] next_addr;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Reject reserved bursts, beats wider than the bus and WRAP lengths that are not 2/4/8/16
  always_comb begin
    wrap_len_ok = (int'(front_AWLEN) == 1) || (int'(front_AWLEN) == 3) ||
                  (int'(front_AWLEN) == 7) || (int'(front_AWLEN) == 15);
    cmd_bad     = (front_AWBURST == BURST_RSVD) ||
                  (int'(front_AWSIZE) > MAX_SIZE) ||
                  ((front_AWBURST == BURST_WRAP) && !wrap_len_ok);
  end

  // Next-state and handshake outputs; pop is held off while reset is asserted so no command is lost to it
  always_comb begin
    state_d   = state_q;
    aw_pop    = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BID       = '0;
    BRESP     = RESP_OKAY;
    mem_we    = 1'b0;
    beat      = 1'b0;
    last_beat = (cnt_q == len_q);
    case (state_q)
      ST_IDLE: begin
        if (!aw_empty && !rst) begin
          aw_pop  = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        WREADY = 1'b1;
        beat   = WVALID;
        mem_we = WVALID && !err_q;
        if (WVALID && last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

  // Command latch at pop, then per-beat counter/address advance and WLAST consistency tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_pop) begin
        id_q    <= front_AWID;
        addr_q  <= front_AWADDR;
        len_q   <= front_AWLEN;
        size_q  <= front_AWSIZE;
        burst_q <= front_AWBURST;
        cnt_q   <= '0;
        err_q   <= cmd_bad;
      end else if (beat) begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= next_addr;
        if (WLAST != last_beat) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_responder.sv
// tb/tb_axi_wr_responder.sv - directed and randomized bench with a burst-level reference model
module tb_axi_wr_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_empty;
  logic        aw_pop;
  logic [3:0]  front_AWID;
  logic [31:0] front_AWADDR;
  logic [3:0]  front_AWLEN;
  logic [2:0]  front_AWSIZE;
  logic [1:0]  front_AWBURST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } cmd_t;

  cmd_t q[$];
  int   total = 0;
  int   bad   = 0;

  axi_wr_responder dut (
    .clk(clk), .rst(rst), .aw_empty(aw_empty), .aw_pop(aw_pop),
    .front_AWID(front_AWID), .front_AWADDR(front_AWADDR), .front_AWLEN(front_AWLEN),
    .front_AWSIZE(front_AWSIZE), .front_AWBURST(front_AWBURST),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cmd_illegal(input cmd_t c);
    bit wrap_ok;
    wrap_ok = (c.len == 4'd1) || (c.len == 4'd3) || (c.len == 4'd7) || (c.len == 4'd15);
    return (c.burst == 2'b11) || (c.size > 3'd2) || (c.burst == 2'b10 && !wrap_ok);
  endfunction

  function automatic logic [31:0] exp_addr(input cmd_t c, input int i);
    logic [31:0] bytes, span, base, off;
    bytes = 32'd1 << c.size;
    span  = (32'(c.len) + 32'd1) * bytes;
    base  = c.addr & ~(span - 32'd1);
    case (c.burst)
      2'b00:   return c.addr;
      2'b01:   return c.addr + 32'(i) * bytes;
      2'b10: begin
        off = (c.addr - base + 32'(i) * bytes) % span;
        return base + off;
      end
      default: return c.addr;
    endcase
  endfunction

  // present the queue front, then let combinational outputs settle
  task automatic settle();
    aw_empty = (q.size() == 0);
    if (q.size() != 0) begin
      front_AWID    = q[0].id;
      front_AWADDR  = q[0].addr;
      front_AWLEN   = q[0].len;
      front_AWSIZE  = q[0].size;
      front_AWBURST = q[0].burst;
    end else begin
      front_AWID = '0; front_AWADDR = '0; front_AWLEN = '0; front_AWSIZE = '0; front_AWBURST = '0;
    end
    #1;
  endtask

  task automatic adv();
    logic p;
    p = aw_pop;
    @(posedge clk);
    if (p && q.size() != 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic run_burst(input int gap_pct, input int bad_last, input int bready_wait);
    cmd_t c;
    bit   cerr, err;
    int   i, n;
    c = q[0];
    WVALID = 1'($urandom_range(0, 1));
    WLAST  = 1'($urandom_range(0, 1));
    BREADY = 1'($urandom_range(0, 1));
    settle();
    chk("pop", aw_pop, 1);
    chk("wready_idle", WREADY, 0);
    chk("we_idle", mem_we, 0);
    chk("bvalid_idle", BVALID, 0);
    adv();
    cerr = cmd_illegal(c);
    err  = cerr;
    i = 0;
    n = 0;
    while (i <= int'(c.len) && n < 200) begin
      WVALID = ($urandom_range(0, 99) >= gap_pct);
      WDATA  = $urandom;
      WSTRB  = 4'($urandom_range(0, 15));
      WLAST  = (i == int'(c.len)) ^ (i == bad_last);
      BREADY = 1'($urandom_range(0, 1));
      settle();
      chk("wready", WREADY, 1);
      chk("pop_data", aw_pop, 0);
      chk("bvalid_data", BVALID, 0);
      if (WVALID) begin
        chk("we", mem_we, !err);
        if (!cerr) chk("addr", mem_addr, exp_addr(c, i));
        chk("wdata", mem_wdata, WDATA);
        chk("wstrb", mem_wstrb, WSTRB);
        if (WLAST != (i == int'(c.len))) err = 1'b1;
        i++;
      end else begin
        chk("we_gap", mem_we, 0);
      end
      adv();
      n++;
    end
    if (n >= 200) chk("beat_timeout", 0, 1);
    WVALID = 1'b0;
    WLAST  = 1'b0;
    for (int k = 0; k < bready_wait; k++) begin
      BREADY = 1'b0;
      settle();
      chk("bvalid_hold", BVALID, 1);
      chk("bid_hold", BID, c.id);
      chk("bresp_hold", BRESP, err ? 2'b10 : 2'b00);
      chk("pop_resp", aw_pop, 0);
      chk("wready_resp", WREADY, 0);
      adv();
    end
    BREADY = 1'b1;
    settle();
    chk("bvalid", BVALID, 1);
    chk("bid", BID, c.id);
    chk("bresp", BRESP, err ? 2'b10 : 2'b00);
    chk("pop_hs", aw_pop, 0);
    adv();
    BREADY = 1'b0;
  endtask

  initial begin
    cmd_t c;
    int bl;
    rst = 1'b1; WVALID = 1'b0; WLAST = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
    @(negedge clk);
    settle();
    adv();
    settle();
    chk("rst_pop", aw_pop, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    adv();

    // INCR then WRAP back to back
    q.push_back('{id: 4'd3, addr: 32'h100, len: 4'd3, size: 3'd2, burst: 2'b01});
    q.push_back('{id: 4'd4, addr: 32'h38,  len: 4'd3, size: 3'd2, burst: 2'b10});
    run_burst(0, -1, 0);
    run_burst(0, -1, 0);
    // early WLAST, reserved burst, oversize beat
    q.push_back('{id: 4'd5, addr: 32'h200, len: 4'd3, size: 3'd2, burst: 2'b01});
    q.push_back('{id: 4'd6, addr: 32'h300, len: 4'd3, size: 3'd2, burst: 2'b11});
    q.push_back('{id: 4'd7, addr: 32'h300, len: 4'd1, size: 3'd3, burst: 2'b01});
    run_burst(0, 1, 0);
    run_burst(0, -1, 0);
    run_burst(0, -1, 0);
    // 16-beat bursts: INCR across the top of the address space, WRAP16
    q.push_back('{id: 4'd8, addr: 32'hFFFF_FFE0, len: 4'd15, size: 3'd2, burst: 2'b01});
    q.push_back('{id: 4'd1, addr: 32'h1234,      len: 4'd15, size: 3'd2, burst: 2'b10});
    run_burst(0, -1, 0);
    run_burst(0, -1, 0);
    // back-pressure on W and B
    q.push_back('{id: 4'd2, addr: 32'h500, len: 4'd3, size: 3'd1, burst: 2'b00});
    q.push_back('{id: 4'd11, addr: 32'h600, len: 4'd7, size: 3'd0, burst: 2'b10});
    run_burst(40, -1, 5);
    run_burst(30, -1, 2);

    // reset after two beats of a four-beat burst
    q.push_back('{id: 4'd9,  addr: 32'h400, len: 4'd3, size: 3'd2, burst: 2'b01});
    q.push_back('{id: 4'd10, addr: 32'h80,  len: 4'd1, size: 3'd1, burst: 2'b10});
    settle();
    chk("mid_pop", aw_pop, 1);
    adv();
    for (int b = 0; b < 2; b++) begin
      WVALID = 1'b1; WLAST = 1'b0; WDATA = $urandom; WSTRB = 4'hF;
      settle();
      chk("mid_we", mem_we, 1);
      chk("mid_addr", mem_addr, 32'h400 + 32'(b) * 32'd4);
      adv();
    end
    WVALID = 1'b0;
    rst = 1'b1;
    settle();
    chk("rst_hold_pop", aw_pop, 0);
    adv();
    rst = 1'b0;
    settle();
    chk("post_rst_wready", WREADY, 0);
    chk("post_rst_bvalid", BVALID, 0);
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_bid", BID, 0);
    chk("post_rst_bresp", BRESP, 0);
    chk("post_rst_front", q[0].id, 4'd10);
    run_burst(0, -1, 1);

    // randomized commands
    for (int r = 0; r < 40; r++) begin
      while (q.size() < 2) begin
        c.id    = 4'($urandom);
        c.addr  = $urandom;
        c.len   = 4'($urandom_range(0, 15));
        c.size  = 3'($urandom_range(0, 3));
        c.burst = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          c.burst = 2'b10;
          c.size  = 3'($urandom_range(0, 2));
          c.len   = 4'((1 << $urandom_range(1, 4)) - 1);
        end
        q.push_back(c);
      end
      bl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(q[0].len))) : -1;
      run_burst(int'($urandom_range(0, 50)), bl, int'($urandom_range(0, 3)));
    end
    while (q.size() != 0) run_burst(20, -1, 1);

    settle();
    chk("end_bvalid", BVALID, 0);
    chk("end_pop", aw_pop, 0);
    chk("end_wready", WREADY, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
